wb_uart_tx: RTL and testbench



---
 rtl/wb_uart_tx_if.sv | 14 +
 rtl/wb_uart_tx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_tx_if.sv
// Wishbone classic bus bundle: 32-bit address/data, 4 byte selects.
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_uart_tx.sv
// Wishbone transmit-only UART: 8N1 framing, programmable divisor, TX FIFO,
// and a level "TX drained" interrupt.
module wb_uart_tx #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
  input  logic  clk_in,
  input  logic  reset_in,
  wb_bus.slave  bus_slave,
  output logic  tx_out,
  output logic  irq_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned DAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Bus handshake and latched write request
  logic             ack_q, ack_d;
  logic [DAT_W-1:0] dat_r_q, dat_r_d;
  logic             wr_q, wr_d;
  logic [1:0]       wadr_q, wadr_d;
  logic [1:0]       wsel_q, wsel_d;
  logic [15:0]      wdat_q, wdat_d;

  // Software-visible registers
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             ctrl_q, ctrl_d;
  logic             ovf_q, ovf_d;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Transmitter
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             irq_q, irq_d;

  logic             req_c;
  logic             full_c;
  logic             empty_c;
  logic             busy_c;
  logic             push_c;
  logic             pop_c;
  logic [DIV_W-1:0] div_eff_c;
  logic [DAT_W-1:0] rdata_c;

  logic unused_bus;
  assign unused_bus = ^{bus_slave.adr[31:4], bus_slave.adr[1:0],
                        bus_slave.sel[3:2], bus_slave.dat_w[31:16]};

  assign req_c     = bus_slave.cyc & bus_slave.stb & ~ack_q;
  assign full_c    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c   = (count_q == '0);
  assign busy_c    = (state_q != ST_IDLE);
  assign div_eff_c = (divisor_q == '0) ? DIV_W'(1) : divisor_q;

  // Read mux is sampled in the request cycle so dat_r is valid alongside ack
  always_comb begin
    rdata_c = '0;
    unique case (bus_slave.adr[3:2])
      2'd0: rdata_c = '0;
      2'd1: rdata_c = {16'd0, 8'(count_q), 4'd0, ovf_q, empty_c, full_c, busy_c};
      2'd2: rdata_c = {16'd0, divisor_q};
      2'd3: rdata_c = {31'd0, ctrl_q};
      default: rdata_c = '0;
    endcase
  end

  // Bus front end and register writes; side effects land in the ack cycle
  always_comb begin
    ack_d     = req_c;
    dat_r_d   = (req_c && !bus_slave.we) ? rdata_c : '0;
    wr_d      = req_c & bus_slave.we;
    wadr_d    = wadr_q;
    wsel_d    = wsel_q;
    wdat_d    = wdat_q;
    divisor_d = divisor_q;
    ctrl_d    = ctrl_q;
    ovf_d     = ovf_q;
    push_c    = 1'b0;

    if (req_c) begin
      wadr_d = bus_slave.adr[3:2];
      wsel_d = bus_slave.sel[1:0];
      wdat_d = bus_slave.dat_w[15:0];
    end

    if (wr_q) begin
      unique case (wadr_q)
        2'd0: begin
          if (wsel_q[0]) begin
            if (full_c) ovf_d = 1'b1;
            else        push_c = 1'b1;
          end
        end
        2'd1: begin
          if (wsel_q[0] && wdat_q[3]) ovf_d = 1'b0;
        end
        2'd2: begin
          if (wsel_q[0]) divisor_d[7:0]  = wdat_q[7:0];
          if (wsel_q[1]) divisor_d[15:8] = wdat_q[15:8];
        end
        2'd3: begin
          if (wsel_q[0]) ctrl_d = wdat_q[0];
        end
        default: ;
      endcase
    end
  end

  // FIFO storage and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = wdat_q[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  // Transmit FSM; tx_d is the line level for the following cycle
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          div_d   = div_eff_c;
          cnt_d   = div_eff_c - DIV_W'(1);
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_q - DIV_W'(1);
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Back-to-back frames: reload straight into START with no idle gap
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            div_d   = div_eff_c;
            cnt_d   = div_eff_c - DIV_W'(1);
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = ctrl_q & empty_c & (state_q == ST_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      ack_q     <= 1'b0;
      dat_r_q   <= '0;
      wr_q      <= 1'b0;
      wadr_q    <= '0;
      wsel_q    <= '0;
      wdat_q    <= '0;
      divisor_q <= DEFAULT_DIVISOR;
      ctrl_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= ST_IDLE;
      div_q     <= DIV_W'(1);
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      ack_q     <= ack_d;
      dat_r_q   <= dat_r_d;
      wr_q      <= wr_d;
      wadr_q    <= wadr_d;
      wsel_q    <= wsel_d;
      wdat_q    <= wdat_d;
      divisor_q <= divisor_d;
      ctrl_q    <= ctrl_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO payload needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  assign bus_slave.ack   = ack_q;
  assign bus_slave.dat_r = dat_r_q;
  assign tx_out          = tx_q;
  assign irq_out         = irq_q;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: bus-level stimulus, line recorder and frame decoder
// that derives expected waveforms from 8N1 framing rules.
module tb_wb_uart_tx;

  localparam int unsigned FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic reset_in = 1'b1;
  logic tx_out;
  logic irq_out;

  wb_bus wb_if ();

  wb_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIVISOR(16'd434)) dut (
    .clk_in   (clk),
    .reset_in (reset_in),
    .bus_slave(wb_if),
    .tx_out   (tx_out),
    .irq_out  (irq_out)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Line level seen in each cycle, keyed by cycle number
  logic rec [int];
  always @(negedge clk) rec[cyc_n] = tx_out;

  int vectors = 0;
  int errors  = 0;
  int last_ack = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] wdat, output logic [31:0] rdat, output int ack_c);
    @(negedge clk);
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = we;
    wb_if.adr = adr;  wb_if.sel = sel;  wb_if.dat_w = wdat;
    @(negedge clk);
    check_eq("ack", 32'(wb_if.ack), 32'd1);
    rdat  = wb_if.dat_r;
    ack_c = cyc_n;
    wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] wdat);
    logic [31:0] dummy;
    bus_xfer(1'b1, adr, sel, wdat, dummy, last_ack);
  endtask

  task automatic bus_rd(input logic [31:0] adr, output logic [31:0] d);
    int dummy;
    bus_xfer(1'b0, adr, 4'hF, 32'd0, d, dummy);
  endtask

  // Advance to the negedge of cycle n (caller sits on a negedge)
  task automatic wait_neg(input int n);
    if (cyc_n > n) check_eq("schedule", 32'(cyc_n), 32'(n));
    while (cyc_n < n) @(negedge clk);
  endtask

  task automatic wait_idle();
    logic [31:0] s = '0;
    for (int i = 0; i < 3000; i++) begin
      bus_rd(32'h4, s);
      if ((s & 32'h7) == 32'h4) return;
    end
    check_eq("idle_timeout", s & 32'h7, 32'h4);
  endtask

  function automatic int find_start(input int from);
    for (int k = from; rec.exists(k); k++)
      if (rec[k] === 1'b0) return k;
    return -1;
  endfunction

  // Every cycle of the 10-bit frame must hold the framed bit value
  task automatic check_frame(input string tag, input int st, input int div,
                             input logic [7:0] exp_b, output int nxt);
    int bad = 0;
    logic [7:0] got = 'x;
    logic e;
    for (int b = 0; b < 10; b++) begin
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
      for (int c = 0; c < div; c++) begin
        if (!rec.exists(st + b*div + c) || rec[st + b*div + c] !== e) bad++;
      end
    end
    for (int b = 1; b <= 8; b++)
      if (rec.exists(st + b*div + div/2)) got[b-1] = rec[st + b*div + div/2];
    check_eq({tag, "_byte"}, 32'(got), 32'(exp_b));
    check_eq({tag, "_bits"}, 32'(bad), 32'd0);
    nxt = st + 10*div;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    logic [7:0]  b [10];
    logic [7:0]  exp_q [$];
    int a, a0, st, pos, nxt, acks, div, n;

    wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0;
    wb_if.adr = '0; wb_if.sel = '0; wb_if.dat_w = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    check_eq("rst_tx", 32'(tx_out), 32'd1);
    check_eq("rst_irq", 32'(irq_out), 32'd0);
    check_eq("rst_ack", 32'(wb_if.ack), 32'd0);
    check_eq("rst_dat_r", wb_if.dat_r, 32'd0);
    bus_rd(32'h4, s);  check_eq("rst_status", s, 32'h4);
    bus_rd(32'h8, s);  check_eq("rst_divisor", s, 32'd434);
    bus_rd(32'hC, s);  check_eq("rst_ctrl", s, 32'd0);
    bus_rd(32'h10, s); check_eq("data_read_alias", s, 32'd0);

    // Held strobe: one ack every two cycles
    @(negedge clk);
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = 1'b0; wb_if.adr = 32'h4;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (wb_if.ack) acks++;
    end
    wb_if.cyc = 1'b0; wb_if.stb = 1'b0;
    check_eq("ack_rate", 32'(acks), 32'd2);

    // Divisor 4, byte 0x55
    bus_wr(32'h8, 4'h3, 32'd4);
    bus_wr(32'h0, 4'h1, 32'h55);
    a = last_ack;
    wait_neg(a + 2 + 38);
    bus_rd(32'h4, s); check_eq("busy_last_stop", s, 32'h5);
    wait_idle();
    st = find_start(a);
    check_eq("x55_start", 32'(st), 32'(a + 2));
    check_frame("x55", st, 4, 8'h55, nxt);
    check_eq("x55_no_extra", 32'(find_start(nxt)), 32'hFFFF_FFFF);

    // Divisor 0 acts as 1
    bus_wr(32'h8, 4'h3, 32'd0);
    bus_rd(32'h8, s); check_eq("div0_read", s, 32'd0);
    b[0] = 8'($urandom);
    bus_wr(32'h0, 4'h1, 32'(b[0]));
    a = last_ack;
    wait_neg(a + 2 + 9);
    bus_rd(32'h4, s); check_eq("div0_idle_at_10", s, 32'h4);
    st = find_start(a);
    check_eq("div0_start", 32'(st), 32'(a + 2));
    check_frame("div0", st, 1, b[0], nxt);

    // Overflow: 10 writes at divisor 2, the 10th is dropped
    bus_wr(32'h8, 4'h3, 32'd2);
    for (int i = 0; i < 10; i++) begin
      b[i] = 8'($urandom);
      bus_wr(32'h0, 4'h1, 32'(b[i]));
      if (i == 0) a0 = last_ack;
    end
    wait_idle();
    bus_rd(32'h4, s); check_eq("ovf_status", s, 32'hC);
    pos = find_start(a0);
    check_eq("ovf_first_start", 32'(pos), 32'(a0 + 2));
    for (int i = 0; i < 9; i++) begin
      st = find_start(pos);
      if (i > 0) check_eq("ovf_gap", 32'(st), 32'(pos));
      check_frame("ovf", st, 2, b[i], pos);
    end
    check_eq("ovf_dropped", 32'(find_start(pos)), 32'hFFFF_FFFF);
    bus_wr(32'h4, 4'h1, 32'h8);
    bus_rd(32'h4, s); check_eq("ovf_cleared", s, 32'h4);

    // Divisor change mid-frame applies to the next frame
    bus_wr(32'h8, 4'h3, 32'd3);
    b[0] = 8'($urandom); b[1] = 8'($urandom);
    bus_wr(32'h0, 4'h1, 32'(b[0])); a0 = last_ack;
    bus_wr(32'h0, 4'h1, 32'(b[1]));
    bus_wr(32'h8, 4'h3, 32'd8);
    wait_idle();
    st = find_start(a0);
    check_eq("chg_start", 32'(st), 32'(a0 + 2));
    check_frame("chg_div3", st, 3, b[0], nxt);
    st = find_start(nxt);
    check_eq("chg_gap", 32'(st), 32'(nxt));
    check_frame("chg_div8", st, 8, b[1], nxt);
    check_eq("chg_no_extra", 32'(find_start(nxt)), 32'hFFFF_FFFF);

    // Interrupt behaviour
    bus_wr(32'h8, 4'h3, 32'd2);
    bus_wr(32'hC, 4'h1, 32'd1);
    a = last_ack;
    wait_neg(a + 1); check_eq("irq_lag", 32'(irq_out), 32'd0);
    wait_neg(a + 2); check_eq("irq_idle_on", 32'(irq_out), 32'd1);
    b[0] = 8'($urandom);
    bus_wr(32'h0, 4'h1, 32'(b[0]));
    a = last_ack; st = a + 2;
    wait_neg(a + 1);  check_eq("irq_pre_drop", 32'(irq_out), 32'd1);
    wait_neg(a + 2);  check_eq("irq_dropped", 32'(irq_out), 32'd0);
    wait_neg(st + 5); check_eq("irq_mid_frame", 32'(irq_out), 32'd0);
    wait_neg(st + 20); check_eq("irq_idle_lag", 32'(irq_out), 32'd0);
    wait_neg(st + 21); check_eq("irq_rise", 32'(irq_out), 32'd1);
    check_frame("irq", find_start(a), 2, b[0], nxt);
    bus_wr(32'hC, 4'h1, 32'd0);
    a = last_ack;
    wait_neg(a + 2); check_eq("irq_disabled", 32'(irq_out), 32'd0);

    // Randomized bursts against the framing model
    for (int it = 0; it < 6; it++) begin
      div = int'($urandom_range(1, 5));
      n   = int'($urandom_range(1, FIFO_DEPTH));
      bus_wr(32'h8, 4'h3, 32'(div));
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(8'($urandom));
        bus_wr(32'h0, 4'h1, 32'(exp_q[i]));
        if (i == 0) a0 = last_ack;
      end
      wait_idle();
      bus_rd(32'h4, s); check_eq("rnd_status", s, 32'h4);
      pos = a0;
      while (exp_q.size() > 0) begin
        st = find_start(pos);
        check_frame("rnd", st, div, exp_q.pop_front(), pos);
      end
      check_eq("rnd_no_extra", 32'(find_start(pos)), 32'hFFFF_FFFF);
    end

    // Reset during data bit 3 with bytes queued
    bus_wr(32'h8, 4'h3, 32'd4);
    b[0] = 8'($urandom) & 8'hF7;
    b[1] = 8'($urandom); b[2] = 8'($urandom);
    bus_wr(32'h0, 4'h1, 32'(b[0])); a0 = last_ack;
    bus_wr(32'h0, 4'h1, 32'(b[1]));
    bus_wr(32'h0, 4'h1, 32'(b[2]));
    st = a0 + 2;
    wait_neg(st + 17);
    reset_in = 1'b1;
    @(negedge clk);
    reset_in = 1'b0;
    check_eq("rst_mid_tx", 32'(tx_out), 32'd1);
    bus_rd(32'h4, s); check_eq("rst_mid_status", s, 32'h4);
    bus_rd(32'h8, s); check_eq("rst_mid_divisor", s, 32'd434);
    wait_neg(cyc_n + 300);
    check_eq("rst_mid_bit3", 32'(rec[st + 17]), 32'd0);
    check_eq("rst_mid_silent", 32'(find_start(st + 18)), 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
